// File: rtl/idex_skid_stage_if.sv
// Valid/ready payload bus between pipeline stages: decode->ID/EX and ID/EX->execute.
interface idex_skid_stage_if #(
    parameter int DATA_W = 256,
    parameter int CTRL_W = 9
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/idex_skid_stage.sv
// ID/EX stage: main register feeding execute plus one skid entry, so in_ready can be
// registered without losing the instruction that arrives in the cycle a stall begins.
module idex_skid_stage #(
    parameter int DATA_W = 256,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    idex_skid_stage_if.slave  dec_if,
    idex_skid_stage_if.master exe_if,
    output logic [CNT_W-1:0] squash_cnt_o
);
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_fire;
    logic             main_free;
    logic             kill_main;
    logic [CNT_W+1:0] cnt_sum;
    entry_t           in_entry;

    assign in_entry  = '{ctrl: dec_if.ctrl, data: dec_if.data};
    assign in_fire   = dec_if.valid & in_ready_q;
    assign main_free = !out_valid_q | exe_if.ready;
    // A main entry consumed by execute in the flush cycle is completed, not squashed.
    assign kill_main = out_valid_q & !exe_if.ready;
    assign cnt_sum   = {2'b00, cnt_q}
                     + {{(CNT_W+1){1'b0}}, kill_main}
                     + {{(CNT_W+1){1'b0}}, skid_valid_q};

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            main_d.ctrl  = '0;
            skid_valid_d = 1'b0;
            cnt_d        = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_d      = skid_q;
                out_valid_d = 1'b1;
                if (in_fire) begin
                    skid_d = in_entry;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                main_d      = in_entry;
                out_valid_d = 1'b1;
            end else begin
                // Bubble: control is forced quiet, payload is left as-is.
                out_valid_d = 1'b0;
                main_d.ctrl = '0;
            end
        end else if (in_fire) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dec_if.ready = in_ready_q;
    assign exe_if.valid = out_valid_q;
    assign exe_if.data  = main_q.data;
    assign exe_if.ctrl  = main_q.ctrl;
    assign squash_cnt_o = cnt_q;
endmodule

// File: tb/tb_idex_skid_stage.sv
// Directed vector bench for idex_skid_stage: a table of per-cycle stimulus/expectations
// plus a hand-written reset-during-stall sequence.
module tb_idex_skid_stage;
    localparam int DW = 256;
    localparam int CW = 9;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [NW-1:0] squash_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    idex_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) dec_if ();
    idex_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) exe_if ();

    idex_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (flush),
        .dec_if       (dec_if),
        .exe_if       (exe_if),
        .squash_cnt_o (squash_cnt)
    );

    typedef struct {
        logic          fl;
        logic          iv;
        logic [DW-1:0] id;
        logic [CW-1:0] ic;
        logic          ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic          erdy;
        logic [NW-1:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic iv, logic [DW-1:0] id, logic [CW-1:0] ic,
                                logic ordy, logic ev, logic [DW-1:0] ed, logic [CW-1:0] ec,
                                logic erdy, logic [NW-1:0] ecnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ec = ec; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic fl, logic iv, logic [DW-1:0] id, logic [CW-1:0] ic,
                         logic ordy);
        reset        = rst;
        flush        = fl;
        dec_if.valid = iv;
        dec_if.data  = id;
        dec_if.ctrl  = ic;
        exe_if.ready = ordy;
    endtask

    task automatic check_all(string tag, logic ev, logic [DW-1:0] ed, logic [CW-1:0] ec,
                             logic erdy, logic [NW-1:0] ecnt);
        chk({tag, ".out_valid"}, DW'(exe_if.valid), DW'(ev));
        chk({tag, ".out_data"},  exe_if.data,       ed);
        chk({tag, ".out_ctrl"},  DW'(exe_if.ctrl),  DW'(ec));
        chk({tag, ".in_ready"},  DW'(dec_if.ready), DW'(erdy));
        chk({tag, ".squash"},    DW'(squash_cnt),   DW'(ecnt));
    endtask

    // Items: payload / control
    localparam logic [DW-1:0] DA = 'hA1, DB = 'hB2, DC = 'hC3, DD = 'hD4, DE = 'hE5,
                              DF = 'hF6, DG = 'h17;
    localparam logic [CW-1:0] CA = 9'h0A5, CB = 9'h011, CC = 9'h1FF, CD = 9'h042,
                              CE = 9'h100, CF = 9'h003, CG = 9'h0C0;

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, '0, '0, 1'b1, 2'd0);

        //           fl iv  id  ic  ordy ev  ed  ec  rdy cnt
        // single instruction, then three idle cycles
        vecs.push_back(mk(0, 1, DA, CA, 1, 1, DA, CA, 1, 0));
        vecs.push_back(mk(0, 0, '0, '0, 1, 0, DA, 0,  1, 0));
        vecs.push_back(mk(0, 0, '0, '0, 1, 0, DA, 0,  1, 0));
        vecs.push_back(mk(0, 0, '0, '0, 1, 0, DA, 0,  1, 0));
        // back-to-back stream, then stall catches D in the skid
        vecs.push_back(mk(0, 1, DB, CB, 1, 1, DB, CB, 1, 0));
        vecs.push_back(mk(0, 1, DC, CC, 1, 1, DC, CC, 1, 0));
        vecs.push_back(mk(0, 1, DD, CD, 0, 1, DC, CC, 0, 0));
        vecs.push_back(mk(0, 1, DE, CE, 0, 1, DC, CC, 0, 0));
        vecs.push_back(mk(0, 1, DE, CE, 1, 1, DD, CD, 1, 0));
        vecs.push_back(mk(0, 1, DE, CE, 1, 1, DE, CE, 1, 0));
        vecs.push_back(mk(0, 0, '0, '0, 1, 0, DE, 0,  1, 0));
        // main=F stalled, skid=G, flush while A is offered
        vecs.push_back(mk(0, 1, DF, CF, 0, 1, DF, CF, 1, 0));
        vecs.push_back(mk(0, 1, DG, CG, 0, 1, DF, CF, 0, 0));
        vecs.push_back(mk(1, 1, DA, CA, 0, 0, DF, 0,  1, 2));
        vecs.push_back(mk(0, 0, '0, '0, 1, 0, DF, 0,  1, 2));
        // flush in the same cycle execute takes A: nothing squashed
        vecs.push_back(mk(0, 1, DA, CA, 1, 1, DA, CA, 1, 2));
        vecs.push_back(mk(1, 0, '0, '0, 1, 0, DA, 0,  1, 2));
        // two more double-kill flushes: counter saturates at 3
        vecs.push_back(mk(0, 1, DB, CB, 0, 1, DB, CB, 1, 2));
        vecs.push_back(mk(0, 1, DC, CC, 0, 1, DB, CB, 0, 2));
        vecs.push_back(mk(1, 0, '0, '0, 0, 0, DB, 0,  1, 3));
        vecs.push_back(mk(0, 1, DD, CD, 0, 1, DD, CD, 1, 3));
        vecs.push_back(mk(0, 1, DE, CE, 0, 1, DD, CD, 0, 3));
        vecs.push_back(mk(1, 0, '0, '0, 0, 0, DD, 0,  1, 3));

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec,
                      vecs[i].erdy, vecs[i].ecnt);
        end

        // reset in the middle of a full stall drops both entries
        drive(1'b0, 1'b0, 1'b1, DF, CF, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, DG, CG, 1'b0);
        @(posedge clk); @(negedge clk);
        check_all("stall_full", 1'b1, DF, CF, 1'b0, 2'd3);
        drive(1'b1, 1'b0, 1'b1, DA, CA, 1'b0);
        @(posedge clk); @(negedge clk);
        check_all("rst_stall", 1'b0, '0, '0, 1'b1, 2'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        @(posedge clk); @(negedge clk);
        check_all("post_rst", 1'b0, '0, '0, 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
